// File: rtl/parametric_register_file.sv
// Multi-read-port, single-write-port register file with one storage replica per read port.
// A hardware clear sweep runs after reset; o_Ready rises once every entry holds CLEAR_VALUE.
module parametric_register_file #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int NUM_READ_PORTS = 8,
  parameter int BYPASS         = 1,
  parameter logic signed [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_WriteEnable,
  input  logic [ADDR_WIDTH-1:0]        i_WriteAddress,
  input  logic signed [DATA_WIDTH-1:0] i_DataIn,
  input  logic [ADDR_WIDTH-1:0]        i_ReadAddress [NUM_READ_PORTS],
  output logic signed [DATA_WIDTH-1:0] o_DataOut [NUM_READ_PORTS],
  output logic                         o_Ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state_reg, state_next;
  // One extra bit so the terminal compare never aliases with a wrapped count.
  logic [ADDR_WIDTH:0]     count_reg, count_next;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic signed [DATA_WIDTH-1:0] mem_data;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg <= ST_CLEAR;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    mem_we     = 1'b0;
    mem_addr   = i_WriteAddress;
    mem_data   = i_DataIn;
    case (state_reg)
      ST_CLEAR: begin
        mem_we     = ~i_Reset;
        mem_addr   = count_reg[ADDR_WIDTH-1:0];
        mem_data   = CLEAR_VALUE;
        count_next = count_reg + 1'b1;
        if (count_reg == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        mem_we = i_WriteEnable & ~i_Reset;
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  assign o_Ready = (state_reg == ST_READY);

  // Every replica sees the same write, so all replicas stay identical.
  generate
    for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_port
      logic signed [DATA_WIDTH-1:0] mem_reg [DEPTH];
      logic signed [DATA_WIDTH-1:0] rd_reg;

      always_ff @(posedge i_Clock) begin
        if (mem_we) begin
          mem_reg[mem_addr] <= mem_data;
        end
      end

      always_ff @(posedge i_Clock) begin
        if (i_Reset || state_reg != ST_READY) begin
          rd_reg <= '0;
        end else if (BYPASS != 0 && i_WriteEnable &&
                     i_ReadAddress[gi] == i_WriteAddress) begin
          rd_reg <= i_DataIn;
        end else begin
          rd_reg <= mem_reg[i_ReadAddress[gi]];
        end
      end

      assign o_DataOut[gi] = rd_reg;
    end
  endgenerate

endmodule

// File: tb/tb_parametric_register_file.sv
// Directed bench: default-parameter file with and without forwarding, plus a small
// 24-bit / 16-entry / 3-port instance whose clear value is all ones.
module tb_parametric_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-size files (forwarding on / off) share one stimulus set.
  logic        rst, we;
  logic [7:0]  waddr;
  logic [15:0] din;
  logic [7:0]  raddr [8];
  logic signed [15:0] dout    [8];
  logic signed [15:0] dout_nb [8];
  logic        ready, ready_nb;

  // Small file.
  logic        s_rst, s_we;
  logic [3:0]  s_waddr;
  logic [23:0] s_din;
  logic [3:0]  s_raddr [3];
  logic signed [23:0] s_dout [3];
  logic        s_ready;

  parametric_register_file dut (
    .i_Clock(clk), .i_Reset(rst), .i_WriteEnable(we), .i_WriteAddress(waddr),
    .i_DataIn(din), .i_ReadAddress(raddr), .o_DataOut(dout), .o_Ready(ready)
  );

  parametric_register_file #(.BYPASS(0)) dut_nb (
    .i_Clock(clk), .i_Reset(rst), .i_WriteEnable(we), .i_WriteAddress(waddr),
    .i_DataIn(din), .i_ReadAddress(raddr), .o_DataOut(dout_nb), .o_Ready(ready_nb)
  );

  parametric_register_file #(
    .DATA_WIDTH(24), .ADDR_WIDTH(4), .NUM_READ_PORTS(3), .BYPASS(1),
    .CLEAR_VALUE(-24'sd1)
  ) dut_s (
    .i_Clock(clk), .i_Reset(s_rst), .i_WriteEnable(s_we), .i_WriteAddress(s_waddr),
    .i_DataIn(s_din), .i_ReadAddress(s_raddr), .o_DataOut(s_dout), .o_Ready(s_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_raddr(input logic [7:0] a);
    for (int p = 0; p < 8; p++) raddr[p] = a;
  endtask

  // Counts post-reset edges: ready must be low through edge 255 and high on edge 256.
  task automatic run_clear(input string tag);
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i == 1 || i == 255) begin
        check($sformatf("%s_ready_e%0d", tag, i), {31'b0, ready}, 32'd0);
      end
    end
    tick();
    check($sformatf("%s_ready_e256", tag), {31'b0, ready}, 32'd1);
    check($sformatf("%s_ready_nb_e256", tag), {31'b0, ready_nb}, 32'd1);
  endtask

  logic [15:0] exp3 [8];
  logic [7:0]  addr3 [8];
  logic [7:0]  zaddr [3];

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; din = '0; set_all_raddr(8'd0);
    s_rst = 1'b1; s_we = 1'b0; s_waddr = '0; s_din = '0;
    for (int p = 0; p < 3; p++) s_raddr[p] = '0;
    addr3 = '{8'd3, 8'd200, 8'd3, 8'd200, 8'd0, 8'd1, 8'd254, 8'd255};
    exp3  = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};
    zaddr = '{8'd0, 8'd127, 8'd255};

    // Test 1: reset, clear sweep, all ports read zero
    tick();
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_dout0", 32'({dout[0]}), 32'd0);
    rst = 1'b0;
    run_clear("t1");
    for (int k = 0; k < 3; k++) begin
      set_all_raddr(zaddr[k]);
      tick();
      for (int p = 0; p < 8; p++) begin
        check($sformatf("t1_a%0d_p%0d", zaddr[k], p), 32'({dout[p]}), 32'd0);
      end
    end

    // Test 3: extreme values, 1-cycle read latency
    we = 1'b1; waddr = 8'd3; din = 16'h7FFF; tick();
    waddr = 8'd200; din = 16'h8000; tick();
    we = 1'b0;
    for (int p = 0; p < 8; p++) raddr[p] = addr3[p];
    check("t3_pre_latency_p0", 32'({dout[0]}), 32'd0);
    tick();
    for (int p = 0; p < 8; p++) begin
      check($sformatf("t3_p%0d", p), 32'({dout[p]}), 32'(exp3[p]));
      check($sformatf("t3_nb_p%0d", p), 32'({dout_nb[p]}), 32'(exp3[p]));
    end

    // Test 4: read/write collision on port 5
    we = 1'b1; waddr = 8'd42; din = 16'h0011; tick();
    din = 16'h00AA; raddr[5] = 8'd42; tick();
    check("t4_bypass_p5", 32'({dout[5]}), 32'h00AA);
    check("t4_nobypass_p5", 32'({dout_nb[5]}), 32'h0011);
    check("t4_bypass_p4_unaffected", 32'({dout[4]}), 32'h0);
    we = 1'b0; tick();
    check("t4_nobypass_next", 32'({dout_nb[5]}), 32'h00AA);
    check("t4_bypass_next", 32'({dout[5]}), 32'h00AA);

    // Test 5: disabled write ignored; reset from READY re-clears
    we = 1'b0; waddr = 8'd9; din = 16'hBEEF; tick();
    raddr[0] = 8'd9; raddr[1] = 8'd3; tick();
    check("t5_we0_addr9", 32'({dout[0]}), 32'h0);
    check("t5_pre_rst_p1", 32'({dout[1]}), 32'h7FFF);
    rst = 1'b1; tick();
    check("t5_rst_ready", {31'b0, ready}, 32'd0);
    check("t5_rst_p1", 32'({dout[1]}), 32'h0);
    rst = 1'b0;
    run_clear("t5");
    tick();
    check("t5_recleared_addr3", 32'({dout[1]}), 32'h0);
    check("t5_recleared_addr3_nb", 32'({dout_nb[1]}), 32'h0);

    // Test 2: reset mid-clear restarts sweep; mid-clear write is dropped
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("t2_mid_ready", {31'b0, ready}, 32'd0);
    check("t2_mid_dout", 32'({dout[1]}), 32'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      if (i == 50) begin we = 1'b1; waddr = 8'd5; din = 16'h1234; end
      else we = 1'b0;
      tick();
      if (i == 200 || i == 255) begin
        check($sformatf("t2_ready_e%0d", i), {31'b0, ready}, 32'd0);
      end
    end
    tick();
    check("t2_ready_e256", {31'b0, ready}, 32'd1);
    set_all_raddr(8'd5); tick();
    check("t2_addr5_p0", 32'({dout[0]}), 32'h0);
    check("t2_addr5_p7", 32'({dout[7]}), 32'h0);

    // Test 6: small file, all-ones clear value
    tick();
    check("t6_rst_ready", {31'b0, s_ready}, 32'd0);
    s_rst = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    check("t6_ready_e15", {31'b0, s_ready}, 32'd0);
    tick();
    check("t6_ready_e16", {31'b0, s_ready}, 32'd1);
    s_raddr = '{4'd0, 4'd7, 4'd15};
    tick();
    for (int p = 0; p < 3; p++) begin
      check($sformatf("t6_clear_p%0d", p), 32'({s_dout[p]}), 32'h00FFFFFF);
    end
    s_we = 1'b1; s_waddr = 4'd15; s_din = 24'h800001; tick();
    s_we = 1'b0;
    for (int p = 0; p < 3; p++) s_raddr[p] = 4'd15;
    tick();
    for (int p = 0; p < 3; p++) begin
      check($sformatf("t6_rt_p%0d", p), 32'({s_dout[p]}), 32'h00800001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
